// File: rtl/reg_transfer_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_transfer_sequencer_if
// Command handshake and register-file control bundle for the register
// transfer sequencer.
//   master : command source (decode/control); drives cmd_*, receives strobes
//   slave  : the sequencer; receives cmd_*, drives bus/load/clear strobes
// Signals:
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/ra/rb/rc/alu_op    command fields
//   bus_sel                   encoded bus mux source index
//   load_enable / reg_clr     per-register load and clear strobes
//   alu_op / alu_go           latched ALU function and result-step strobe
//   busy / done / err         status
//   abort                     only when SEQ_ABORT_EN is defined
// ---------------------------------------------------------------------------
interface reg_transfer_sequencer_if #(
    parameter int REGISTERS = 25,
    parameter int SEL_W     = 5
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [SEL_W-1:0]     cmd_ra;
    logic [SEL_W-1:0]     cmd_rb;
    logic [SEL_W-1:0]     cmd_rc;
    logic [3:0]           cmd_alu_op;
    logic [SEL_W-1:0]     bus_sel;
    logic [REGISTERS-1:0] load_enable;
    logic [REGISTERS-1:0] reg_clr;
    logic [3:0]           alu_op;
    logic                 alu_go;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef SEQ_ABORT_EN
    logic                 abort;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_alu_op,
`ifdef SEQ_ABORT_EN
        output abort,
`endif
        input  cmd_ready, bus_sel, load_enable, reg_clr, alu_op, alu_go,
               busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_alu_op,
`ifdef SEQ_ABORT_EN
        input  abort,
`endif
        output cmd_ready, bus_sel, load_enable, reg_clr, alu_op, alu_go,
               busy, done, err
    );
endinterface

// File: rtl/reg_transfer_sequencer.sv
// ---------------------------------------------------------------------------
// reg_transfer_sequencer
// Micro-step sequencer for the register file. Accepts one command at a time
// (NOP, MOVE, ALU, WIDE, CLEAR) and steps through T1..T4 driving the bus
// source select, one-hot load enables, per-register clears and the ALU
// strobe. Outputs are decoded from state and latched command fields only.
// Ports:
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset (forces IDLE, outputs zero)
//   bus  : reg_transfer_sequencer_if.slave (handshake, fields, strobes)
// Optional: define SEQ_ABORT_EN to add bus.abort, which ends any active
// command immediately with done+err and suppresses that cycle's strobes.
// ---------------------------------------------------------------------------
module reg_transfer_sequencer #(
    parameter int REGISTERS = 25,
    parameter int SEL_W     = 5,
    parameter int Y_IDX     = 18,
    parameter int ZLO_IDX   = 19,
    parameter int ZHI_IDX   = 20,
    parameter int HI_IDX    = 22,
    parameter int LO_IDX    = 23
) (
    input logic                     clk,
    input logic                     clr,
    reg_transfer_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MOVE  = 3'd1;
    localparam logic [2:0] OP_ALU   = 3'd2;
    localparam logic [2:0] OP_WIDE  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q;
    logic [SEL_W-1:0] ra_q, rb_q, rc_q;
    logic [3:0]       alu_op_q;
    logic             bad_q;
    logic             accept;
    logic             abort_act;

    function automatic logic [REGISTERS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [REGISTERS-1:0] oh;
        for (int i = 0; i < REGISTERS; i++) begin
            oh[i] = (idx == SEL_W'(i));
        end
        return oh;
    endfunction

    function automatic logic idx_bad(input logic [SEL_W-1:0] idx);
        return !(32'(idx) < REGISTERS);
    endfunction

    // Only the fields an opcode actually uses are range-checked.
    function automatic logic cmd_bad(input logic [2:0] op, input logic [SEL_W-1:0] ra,
                                     input logic [SEL_W-1:0] rb, input logic [SEL_W-1:0] rc);
        logic b;
        case (op)
            OP_NOP:   b = 1'b0;
            OP_MOVE:  b = idx_bad(ra) || idx_bad(rc);
            OP_ALU:   b = idx_bad(ra) || idx_bad(rb) || idx_bad(rc);
            OP_WIDE:  b = idx_bad(ra) || idx_bad(rb);
            OP_CLEAR: b = idx_bad(rc);
            default:  b = 1'b1;
        endcase
        return b;
    endfunction

    assign accept = bus.cmd_valid && (state_q == S_IDLE);

`ifdef SEQ_ABORT_EN
    assign abort_act = bus.abort && (state_q != S_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            alu_op_q <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= bus.cmd_op;
                ra_q     <= bus.cmd_ra;
                rb_q     <= bus.cmd_rb;
                rc_q     <= bus.cmd_rc;
                alu_op_q <= bus.cmd_alu_op;
                bad_q    <= cmd_bad(bus.cmd_op, bus.cmd_ra, bus.cmd_rb, bus.cmd_rc);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_T1;
            // Only ALU and WIDE continue past T1; invalid commands end here.
            S_T1:   state_d = (!bad_q && (op_q == OP_ALU || op_q == OP_WIDE)) ? S_T2 : S_IDLE;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (op_q == OP_WIDE) ? S_T4 : S_IDLE;
            S_T4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_act) state_d = S_IDLE;
    end

    always_comb begin
        bus.bus_sel     = '0;
        bus.load_enable = '0;
        bus.reg_clr     = '0;
        bus.alu_go      = 1'b0;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        case (state_q)
            S_T1: begin
                if (bad_q) begin
                    bus.done = 1'b1;
                    bus.err  = 1'b1;
                end else begin
                    case (op_q)
                        OP_MOVE: begin
                            bus.bus_sel     = ra_q;
                            bus.load_enable = onehot(rc_q);
                            bus.done        = 1'b1;
                        end
                        OP_ALU, OP_WIDE: begin
                            bus.bus_sel     = ra_q;
                            bus.load_enable = onehot(SEL_W'(Y_IDX));
                        end
                        OP_CLEAR: begin
                            bus.reg_clr = onehot(rc_q);
                            bus.done    = 1'b1;
                        end
                        default: bus.done = 1'b1;
                    endcase
                end
            end
            S_T2: begin
                bus.bus_sel     = rb_q;
                bus.alu_go      = 1'b1;
                bus.load_enable = onehot(SEL_W'(ZLO_IDX)) | onehot(SEL_W'(ZHI_IDX));
            end
            S_T3: begin
                bus.bus_sel = SEL_W'(ZLO_IDX);
                if (op_q == OP_WIDE) begin
                    bus.load_enable = onehot(SEL_W'(LO_IDX));
                end else begin
                    bus.load_enable = onehot(rc_q);
                    bus.done        = 1'b1;
                end
            end
            S_T4: begin
                bus.bus_sel     = SEL_W'(ZHI_IDX);
                bus.load_enable = onehot(SEL_W'(HI_IDX));
                bus.done        = 1'b1;
            end
            default: ;
        endcase
        // Abort overrides the step: no side effects, report done+err.
        if (abort_act) begin
            bus.load_enable = '0;
            bus.reg_clr     = '0;
            bus.alu_go      = 1'b0;
            bus.done        = 1'b1;
            bus.err         = 1'b1;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
module tb_reg_transfer_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_transfer_sequencer_if #(.REGISTERS(25), .SEL_W(5)) bif ();

    reg_transfer_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
    );

    typedef struct {
        logic [4:0]  sel;
        logic [24:0] le;
        logic [24:0] rcl;
        logic        go;
        logic        done;
        logic        err;
    } step_t;

    step_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] bit25(input int idx);
        logic [24:0] one = 25'd1;
        return one << idx;
    endfunction

    function automatic void push(input int sel, input logic [24:0] le, input logic [24:0] rcl,
                                 input logic go, input logic done, input logic err);
        step_t s;
        s.sel = 5'(sel); s.le = le; s.rcl = rcl; s.go = go; s.done = done; s.err = err;
        exp_q.push_back(s);
    endfunction

    // Reference: list of expected per-cycle step outputs for one command.
    function automatic void model(input logic [2:0] op, input logic [4:0] ra,
                                  input logic [4:0] rb, input logic [4:0] rc);
        bit bad;
        bit ua, ub, uc;
        exp_q.delete();
        ua = (op == 1 || op == 2 || op == 3);
        ub = (op == 2 || op == 3);
        uc = (op == 1 || op == 2 || op == 4);
        bad = (op > 4) || (ua && ra > 24) || (ub && rb > 24) || (uc && rc > 24);
        if (bad) begin
            push(0, 0, 0, 0, 1, 1);
            return;
        end
        case (op)
            0: push(0, 0, 0, 0, 1, 0);
            1: push(int'(ra), bit25(int'(rc)), 0, 0, 1, 0);
            2: begin
                push(int'(ra), bit25(18), 0, 0, 0, 0);
                push(int'(rb), bit25(19) | bit25(20), 0, 1, 0, 0);
                push(19, bit25(int'(rc)), 0, 0, 1, 0);
            end
            3: begin
                push(int'(ra), bit25(18), 0, 0, 0, 0);
                push(int'(rb), bit25(19) | bit25(20), 0, 1, 0, 0);
                push(19, bit25(23), 0, 0, 0, 0);
                push(20, bit25(22), 0, 0, 1, 0);
            end
            default: push(0, 0, bit25(int'(rc)), 0, 1, 0);
        endcase
    endfunction

    task automatic check_step(input string tag, input int k, input logic [3:0] aop);
        step_t e;
        e = exp_q[k];
        check_eq($sformatf("%s.s%0d.bus_sel", tag, k), 32'(bif.bus_sel), 32'(e.sel));
        check_eq($sformatf("%s.s%0d.load_en", tag, k), 32'(bif.load_enable), 32'(e.le));
        check_eq($sformatf("%s.s%0d.reg_clr", tag, k), 32'(bif.reg_clr), 32'(e.rcl));
        check_eq($sformatf("%s.s%0d.go_done_err_busy_rdy", tag, k),
                 32'({bif.alu_go, bif.done, bif.err, bif.busy, bif.cmd_ready}),
                 32'({e.go, e.done, e.err, 1'b1, 1'b0}));
        if (e.go) check_eq($sformatf("%s.s%0d.alu_op", tag, k), 32'(bif.alu_op), 32'(aop));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".idle_sel"}, 32'(bif.bus_sel), 32'd0);
        check_eq({tag, ".idle_le_clr"}, 32'({bif.load_enable, bif.reg_clr}), 32'd0);
        check_eq({tag, ".idle_go_done_err_busy_rdy"},
                 32'({bif.alu_go, bif.done, bif.err, bif.busy, bif.cmd_ready}), 32'b00001);
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] rc, input logic [3:0] aop);
        bif.cmd_valid  = 1'b1;
        bif.cmd_op     = op;
        bif.cmd_ra     = ra;
        bif.cmd_rb     = rb;
        bif.cmd_rc     = rc;
        bif.cmd_alu_op = aop;
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rc, input logic [3:0] aop,
                           input bit noise);
        model(op, ra, rb, rc);
        drive_cmd(op, ra, rb, rc, aop);
        @(posedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check_step(tag, k, aop);
            // Commands offered while busy must be ignored.
            if (noise) begin
                drive_cmd(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                          4'($urandom));
                bif.cmd_valid = 1'($urandom_range(0, 1));
            end else begin
                bif.cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_idle(tag);
        bif.cmd_valid = 1'b0;
    endtask

    function automatic logic [4:0] rnd_idx();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
    endfunction

    initial begin
        bif.cmd_valid  = 1'b0;
        bif.cmd_op     = '0;
        bif.cmd_ra     = '0;
        bif.cmd_rb     = '0;
        bif.cmd_rc     = '0;
        bif.cmd_alu_op = '0;
`ifdef SEQ_ABORT_EN
        bif.abort      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst.outputs", 32'({bif.bus_sel, bif.alu_op, bif.alu_go, bif.busy, bif.done, bif.err}), 32'd0);
        check_eq("rst.le_clr", 32'({bif.load_enable, bif.reg_clr}), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        check_eq("post_rst.alu_op", 32'(bif.alu_op), 32'd0);

        // Directed cases from the command set and its corners.
        run_cmd("move_3_7",   3'd1, 5'd3,  5'd0, 5'd7,  4'h0, 1'b0);
        run_cmd("alu_1_2_5",  3'd2, 5'd1,  5'd2, 5'd5,  4'h4, 1'b0);
        run_cmd("wide_4_6",   3'd3, 5'd4,  5'd6, 5'd0,  4'h9, 1'b0);
        run_cmd("clear_12",   3'd4, 5'd0,  5'd0, 5'd12, 4'h0, 1'b0);
        run_cmd("move_rc25",  3'd1, 5'd2,  5'd0, 5'd25, 4'h0, 1'b0);
        run_cmd("nop",        3'd0, 5'd31, 5'd31, 5'd31, 4'h0, 1'b0);
        run_cmd("reserved",   3'd6, 5'd1,  5'd1, 5'd1,  4'h0, 1'b0);
        run_cmd("move_reload",3'd1, 5'd9,  5'd0, 5'd9,  4'h0, 1'b0);
        run_cmd("alu_rc_y",   3'd2, 5'd3,  5'd4, 5'd18, 4'hC, 1'b1);
        run_cmd("clear_hi",   3'd4, 5'd0,  5'd0, 5'd22, 4'h0, 1'b1);
        run_cmd("wide_rb31",  3'd3, 5'd1,  5'd31, 5'd0, 4'h2, 1'b0);
        run_cmd("move_rb_unused", 3'd1, 5'd24, 5'd30, 5'd0, 4'h0, 1'b0);

        // Async clear in T2 of an ALU command.
        model(3'd2, 5'd1, 5'd2, 5'd5);
        drive_cmd(3'd2, 5'd1, 5'd2, 5'd5, 4'h4);
        @(posedge clk);
        @(negedge clk);
        check_step("alu_clr", 0, 4'h4);
        bif.cmd_valid = 1'b0;
        @(negedge clk);
        check_step("alu_clr", 1, 4'h4);
        #2 clr = 1'b1;
        #1;
        check_eq("clr_mid.sel_alu_go_busy_done_err",
                 32'({bif.bus_sel, bif.alu_op, bif.alu_go, bif.busy, bif.done, bif.err}), 32'd0);
        check_eq("clr_mid.le_clr", 32'({bif.load_enable, bif.reg_clr}), 32'd0);
        @(negedge clk);
        check_eq("clr_hold.busy_done", 32'({bif.busy, bif.done}), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check_idle("post_clr");
        run_cmd("move_after_clr", 3'd1, 5'd8, 5'd0, 5'd11, 4'h0, 1'b0);

`ifdef SEQ_ABORT_EN
        // Abort in T2 of WIDE.
        model(3'd3, 5'd4, 5'd6, 5'd0);
        drive_cmd(3'd3, 5'd4, 5'd6, 5'd0, 4'h3);
        @(posedge clk);
        @(negedge clk);
        check_step("wide_abort", 0, 4'h3);
        bif.cmd_valid = 1'b0;
        @(negedge clk);
        bif.abort = 1'b1;
        #1;
        check_eq("abort.le_clr", 32'({bif.load_enable, bif.reg_clr}), 32'd0);
        check_eq("abort.go_done_err", 32'({bif.alu_go, bif.done, bif.err}), 32'b011);
        @(negedge clk);
        bif.abort = 1'b0;
        check_idle("post_abort");
        // Abort while idle has no effect.
        bif.abort = 1'b1;
        #1;
        check_idle("abort_idle");
        bif.abort = 1'b0;
        @(negedge clk);
        run_cmd("move_after_abort", 3'd1, 5'd1, 5'd0, 5'd2, 4'h0, 1'b0);
`endif

        // Randomized command stream with random gaps and busy-time noise.
        for (int n = 0; n < 200; n++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_cmd($sformatf("rnd%0d_op%0d", n, op), op, rnd_idx(), rnd_idx(), rnd_idx(),
                    4'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("rnd_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_transfer_sequencer.md
Name: reg_transfer_sequencer

Overview:
- Micro-step sequencer for the 25-entry register file. Accepts one register-transfer command at a time over a valid/ready handshake.
- For each step it drives the bus-source select, the one-hot per-register load enables and the per-register clears.
- Sits between instruction decode / control logic and the register file plus bus mux.
- Handles four command types:
  - MOVE: single bus transfer.
  - ALU: Y <- Ra; Z <- ALU(Y, Rb); Rc <- ZLO.
  - WIDE: multiply/divide into HI/LO.
  - CLEAR.

Parameters:
REGISTERS, 25, number of registers; width of load_enable/reg_clr
SEL_W, 5, width of bus_sel and every register index field
Y_IDX, 18, index of rY
ZLO_IDX, 19, index of rZ lower
ZHI_IDX, 20, index of rZ upper
HI_IDX, 22, index of HI
LO_IDX, 23, index of LO

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  reset; asynchronous, active-high; forces IDLE and zeroes all outputs
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  3  000 NOP, 001 MOVE, 010 ALU, 011 WIDE, 100 CLEAR, 101-111 reserved
cmd_ra  input  SEL_W  source A (MOVE source)
cmd_rb  input  SEL_W  source B
cmd_rc  input  SEL_W  destination (MOVE/ALU/CLEAR)
cmd_alu_op  input  4  ALU function code, latched at accept
bus_sel  output  SEL_W  encoded register index driving the bus mux
load_enable  output  REGISTERS  one-hot (or zero) register load strobes
reg_clr  output  REGISTERS  per-register clear strobes
alu_op  output  4  latched function; valid while alu_go high
alu_go  output  1  ALU result step strobe
busy  output  1  high in any non-IDLE state
done  output  1  one-cycle pulse on the final step of a command
err  output  1  one-cycle pulse, coincident with done, for rejected commands

Behaviour:
- Reset values: cmd_ready=1 (in IDLE after reset is released); all other outputs 0. State=IDLE. Latched fields=0.
- Accept: when cmd_valid && cmd_ready on a clock edge, op/ra/rb/rc/alu_op are latched. cmd_valid while busy is ignored; the command is not queued.
- Outputs are a Moore decode of state plus latched fields. There is no combinational path from cmd_* to any output.
- States: IDLE, T1, T2, T3, T4. Accept always moves to T1. After the last step of the op, return to IDLE. Let N be the accept edge; cycle N+1 is T1.
  - NOP: T1 has no loads; done=1.
  - MOVE: T1: bus_sel=ra, load_enable[rc]=1, done=1. Total 1 step.
  - ALU:
    - T1: bus_sel=ra, load_enable[Y_IDX].
    - T2: bus_sel=rb, alu_go=1, load_enable[ZLO_IDX] and [ZHI_IDX].
    - T3: bus_sel=ZLO_IDX, load_enable[rc], done=1.
  - WIDE:
    - T1: bus_sel=ra, load_enable[Y_IDX].
    - T2: bus_sel=rb, alu_go, load_enable[ZLO_IDX] and [ZHI_IDX].
    - T3: bus_sel=ZLO_IDX, load_enable[LO_IDX].
    - T4: bus_sel=ZHI_IDX, load_enable[HI_IDX], done=1.
  - CLEAR: T1: reg_clr[rc]=1, done=1.
- cmd_ready returns high the cycle after done. Minimum command spacing is therefore steps+1 cycles.
- Validity check at accept:
  - Any used index >= REGISTERS, or a reserved opcode, marks the command invalid.
  - Invalid command: T1 drives no loads and no clears, and bus_sel=0, alu_go=0. done=1 and err=1 in T1. Then IDLE.
  - Unused fields (e.g. rb for MOVE) are not checked.
- Legal corner cases:
  - MOVE with ra==rc is a reload.
  - ALU with rc==Y_IDX overwrites Y at T3.
  - CLEAR of any index including Y/Z/HI/LO.
- Outside active steps bus_sel=0 and load_enable=0.
- load_enable never has more than one bit set, except in T2 (ZLO and ZHI together).
- Async clr mid-command: immediate return to IDLE, all strobes drop within the same cycle, no done pulse, the command is lost.

Optional Feature:
SEQ_ABORT_EN
- Defined: adds input abort (1 bit).
  - abort sampled high in any non-IDLE state: the next state is IDLE.
  - During the cycle abort is high, load_enable, reg_clr and alu_go are forced to 0.
  - done and err pulse together in that cycle.
  - abort in IDLE is ignored. abort takes priority over a step's normal done.
- Not defined: the port is absent and commands always run to completion.

Test Plan:
- Reset, then MOVE ra=3 rc=7 -> T1: bus_sel=3, load_enable=0x0000080, done=1; cmd_ready=0 in T1, =1 the next cycle.
- ALU ra=1 rb=2 rc=5 alu_op=0x4 ->
  - T1: bus_sel=1, load_enable=bit18.
  - T2: bus_sel=2, alu_go=1, alu_op=0x4, load_enable=bits19|20.
  - T3: bus_sel=19, load_enable=bit5, done=1.
- WIDE ra=4 rb=6 -> T3: load_enable=bit23, bus_sel=19; T4: load_enable=bit22, bus_sel=20, done=1. busy high for exactly 4 cycles.
- CLEAR rc=12 -> reg_clr=bit12 for one cycle and load_enable=0. Separately, MOVE rc=25 -> done=1, err=1, load_enable=0.
- Assert clr during T2 of ALU -> outputs 0 before the next edge, state IDLE, no done. A MOVE issued after release completes normally.
- With SEQ_ABORT_EN: abort in T2 of WIDE -> that cycle load_enable=0, alu_go=0, done=1, err=1; next cycle IDLE, cmd_ready=1.
